// File: rtl/mac_tx_arb_pkg.sv
// Shared types and constants for the mac_tx_arb frame arbiter.
package mac_tx_arb_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_STREAM = 3'd1;
    localparam logic [2:0] ST_TRUNC  = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_GAP    = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        STREAM = ST_STREAM,
        TRUNC  = ST_TRUNC,
        DRAIN  = ST_DRAIN,
        GAP    = ST_GAP
    } state_t;

    localparam int DEFAULT_MAX_LEN = 1518;
    localparam int LEN_W = $clog2(DEFAULT_MAX_LEN + 1);
    localparam logic [7:0] TRUNC_FILL = 8'h00;

    // Frame length counter width for an arbitrary MAX_LEN.
    function automatic int len_w_of(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/mac_tx_arb_rr_arbiter.sv
// One-hot request arbiter; round-robin by default, fixed lowest-index-wins
// priority when MAC_TX_ARB_STRICT_PRIO_EN is defined.
module rr_arbiter #(
    parameter int NPORT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NPORT-1:0] req,
    input  logic             accept,
    output logic [NPORT-1:0] gnt
);

`ifdef MAC_TX_ARB_STRICT_PRIO_EN
    always_comb begin
        gnt = '0;
        for (int i = NPORT - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
            end
        end
    end
`else
    localparam int PTR_W = (NPORT > 1) ? $clog2(NPORT) : 1;

    logic [PTR_W-1:0] last_reg;
    logic [PTR_W-1:0] pick;
    logic             found;
    int               idx;

    // Scan downwards so the port nearest after last_reg is the final hit.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        pick  = last_reg;
        idx   = 0;
        for (int k = NPORT; k >= 1; k--) begin
            idx = (int'(last_reg) + k) % NPORT;
            if (req[idx]) begin
                found = 1'b1;
                pick  = PTR_W'(idx);
            end
        end
        if (found) gnt[pick] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_reg <= PTR_W'(NPORT - 1);
        end else if (accept && found) begin
            last_reg <= pick;
        end
    end
`endif

endmodule

// File: rtl/mac_tx_arb.sv
// Frame-level arbiter feeding one mac_rgmii TX port from NPORT sources.
// Build option: MAC_TX_ARB_STRICT_PRIO_EN selects fixed priority instead of round-robin.
module mac_tx_arb
    import mac_tx_arb_pkg::*;
#(
    parameter int NPORT      = 3,
    parameter int MAX_LEN    = 1518,
    parameter int IFG_CYCLES = 12,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NPORT*8-1:0] req_data,
    input  logic [NPORT-1:0]   req_valid,
    input  logic [NPORT-1:0]   req_sof,
    input  logic [NPORT-1:0]   req_eof,
    output logic [NPORT-1:0]   req_ready,
    output logic [7:0]         mac_tx_data,
    output logic               mac_tx_valid,
    output logic               mac_tx_sof,
    output logic               mac_tx_eof,
    output logic [NPORT-1:0]   grant,
    output logic               busy,
    output logic [CNT_W-1:0]   underrun_cnt,
    output logic [CNT_W-1:0]   oversize_cnt
);

    localparam int TX_LEN_W = len_w_of(MAX_LEN);
    localparam int GAP_W    = $clog2(IFG_CYCLES + 1);
    localparam logic [TX_LEN_W-1:0] LEN_LAST = TX_LEN_W'(MAX_LEN - 1);
    localparam logic [GAP_W-1:0]    GAP_INIT = GAP_W'(IFG_CYCLES - 1);

    state_t              state_reg;
    logic [NPORT-1:0]    grant_reg;
    logic [TX_LEN_W-1:0] len_reg;
    logic [GAP_W-1:0]    gap_cnt_reg;
    logic [7:0]          tx_data_reg;
    logic                tx_valid_reg;
    logic                tx_sof_reg;
    logic                tx_eof_reg;
    logic [CNT_W-1:0]    underrun_cnt_reg;
    logic [CNT_W-1:0]    oversize_cnt_reg;

    logic [7:0]       port_data [NPORT];
    logic [7:0]       sel_data;
    logic             sel_valid;
    logic             sel_eof;
    logic [NPORT-1:0] req_vec;
    logic [NPORT-1:0] arb_gnt;
    logic             arb_accept;

    generate
        for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
            assign port_data[gi] = req_data[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (grant_reg[i]) sel_data = sel_data | port_data[i];
        end
    end

    assign sel_valid  = |(req_valid & grant_reg);
    assign sel_eof    = |(req_eof & grant_reg);
    assign req_vec    = req_valid & req_sof;
    assign arb_accept = (state_reg == IDLE) && (|req_vec) && !rst;

    rr_arbiter #(.NPORT(NPORT)) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req_vec),
        .accept (arb_accept),
        .gnt    (arb_gnt)
    );

    // Stray mid-frame bytes at a head are eaten in IDLE so they never block a port.
    always_comb begin
        req_ready = '0;
        if (!rst) begin
            case (state_reg)
                IDLE:                 req_ready = req_valid & ~req_sof;
                STREAM, TRUNC, DRAIN: req_ready = grant_reg;
                default:              req_ready = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            grant_reg        <= '0;
            len_reg          <= '0;
            gap_cnt_reg      <= '0;
            tx_data_reg      <= '0;
            tx_valid_reg     <= 1'b0;
            tx_sof_reg       <= 1'b0;
            tx_eof_reg       <= 1'b0;
            underrun_cnt_reg <= '0;
            oversize_cnt_reg <= '0;
        end else begin
            tx_data_reg  <= '0;
            tx_valid_reg <= 1'b0;
            tx_sof_reg   <= 1'b0;
            tx_eof_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (|req_vec) begin
                        grant_reg <= arb_gnt;
                        len_reg   <= '0;
                        state_reg <= STREAM;
                    end
                end
                STREAM: begin
                    if (sel_valid) begin
                        tx_data_reg  <= sel_data;
                        tx_valid_reg <= 1'b1;
                        tx_sof_reg   <= (len_reg == '0);
                        len_reg      <= len_reg + TX_LEN_W'(1);
                        if (sel_eof) begin
                            tx_eof_reg  <= 1'b1;
                            grant_reg   <= '0;
                            gap_cnt_reg <= GAP_INIT;
                            state_reg   <= GAP;
                        end else if (len_reg == LEN_LAST) begin
                            tx_eof_reg <= 1'b1;
                            if (oversize_cnt_reg != '1)
                                oversize_cnt_reg <= oversize_cnt_reg + CNT_W'(1);
                            state_reg <= DRAIN;
                        end
                    end else begin
                        // Fill byte goes out right behind the last good one, keeping valid contiguous.
                        tx_data_reg  <= TRUNC_FILL;
                        tx_valid_reg <= 1'b1;
                        tx_sof_reg   <= (len_reg == '0);
                        tx_eof_reg   <= 1'b1;
                        if (underrun_cnt_reg != '1)
                            underrun_cnt_reg <= underrun_cnt_reg + CNT_W'(1);
                        state_reg <= TRUNC;
                    end
                end
                TRUNC, DRAIN: begin
                    if (sel_valid && sel_eof) begin
                        grant_reg   <= '0;
                        gap_cnt_reg <= GAP_INIT;
                        state_reg   <= GAP;
                    end else begin
                        state_reg <= DRAIN;
                    end
                end
                GAP: begin
                    if (gap_cnt_reg == '0) state_reg <= IDLE;
                    else                   gap_cnt_reg <= gap_cnt_reg - GAP_W'(1);
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign mac_tx_data  = tx_data_reg;
    assign mac_tx_valid = tx_valid_reg;
    assign mac_tx_sof   = tx_sof_reg;
    assign mac_tx_eof   = tx_eof_reg;
    assign grant        = grant_reg;
    assign busy         = (state_reg != IDLE);
    assign underrun_cnt = underrun_cnt_reg;
    assign oversize_cnt = oversize_cnt_reg;

endmodule

// File: tb/tb_mac_tx_arb.sv
// Randomised frame traffic against mac_tx_arb, checked with a frame-level reference model.
module tb_mac_tx_arb;

    localparam int NPORT = 3;
    localparam int MAX_LEN = 100;
    localparam int IFG = 12;
    localparam int CNT_W = 16;
    localparam int DEPTH = 4096;
    localparam int MAXF = 32;
    localparam int MAXB = 160;

    logic               clk = 1'b0;
    logic               rst;
    logic [NPORT*8-1:0] req_data;
    logic [NPORT-1:0]   req_valid, req_sof, req_eof, req_ready;
    logic [7:0]         mac_tx_data;
    logic               mac_tx_valid, mac_tx_sof, mac_tx_eof;
    logic [NPORT-1:0]   grant;
    logic               busy;
    logic [CNT_W-1:0]   underrun_cnt, oversize_cnt;

    always #5 clk = ~clk;

    mac_tx_arb #(.NPORT(NPORT), .MAX_LEN(MAX_LEN), .IFG_CYCLES(IFG), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req_data(req_data), .req_valid(req_valid), .req_sof(req_sof), .req_eof(req_eof),
        .req_ready(req_ready),
        .mac_tx_data(mac_tx_data), .mac_tx_valid(mac_tx_valid),
        .mac_tx_sof(mac_tx_sof), .mac_tx_eof(mac_tx_eof),
        .grant(grant), .busy(busy),
        .underrun_cnt(underrun_cnt), .oversize_cnt(oversize_cnt)
    );

    typedef struct packed {logic [7:0] gap; logic sof; logic eof; logic [7:0] d;} item_t;
    typedef struct packed {logic [1:0] owner; logic sof; logic eof; logic [7:0] data;} out_t;

    int checks = 0;
    int errors = 0;

    // Source side: per-port byte streams, gap = idle cycles before that byte is offered.
    item_t src_mem [NPORT][DEPTH];
    int    head [NPORT];
    int    tail [NPORT];
    int    hold [NPORT];

    // Reference model: expected MAC output per frame, then scheduled by the arbitration rule.
    out_t  fbuf [NPORT][MAXF][MAXB];
    int    flen [NPORT][MAXF];
    int    nfr  [NPORT];
    out_t  exp_q [$];
    int    last_port;
    int    exp_under, exp_over;

    int    cyc = 0;
    int    last_eof = 0;
    bit    have_eof = 0;
    bit    in_frame = 0;
    int    out_seen = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic push_item(input int p, input item_t it);
        if (head[p] == tail[p]) hold[p] = int'(it.gap);
        src_mem[p][tail[p]] = it;
        tail[p]++;
    endtask

    task automatic drive();
        item_t it;
        for (int p = 0; p < NPORT; p++) begin
            if (head[p] != tail[p] && hold[p] == 0) begin
                it = src_mem[p][head[p]];
                req_valid[p] = 1'b1;
                req_sof[p]   = it.sof;
                req_eof[p]   = it.eof;
                req_data[p*8 +: 8] = it.d;
            end else begin
                req_valid[p] = 1'b0;
                req_sof[p]   = 1'b0;
                req_eof[p]   = 1'b0;
                req_data[p*8 +: 8] = 8'h00;
            end
        end
    endtask

    task automatic monitor();
        out_t e;
        if (!busy) check("grant_idle", 32'(grant), 0);
        if (mac_tx_valid) begin
            out_seen++;
            if (exp_q.size() == 0) begin
                check("tx_extra", 32'(mac_tx_valid), 0);
            end else begin
                e = exp_q.pop_front();
                check("tx_byte", {mac_tx_sof, mac_tx_eof, mac_tx_data}, {e.sof, e.eof, e.data});
                if (mac_tx_sof && have_eof) check("ifg", 32'((cyc - last_eof) >= IFG + 2), 1);
                if (mac_tx_sof && !mac_tx_eof) check("grant", 32'(grant), 32'(1) << e.owner);
            end
            in_frame = !mac_tx_eof;
            if (mac_tx_eof) begin
                last_eof = cyc;
                have_eof = 1;
            end
        end else begin
            check("tx_qual", {mac_tx_sof, mac_tx_eof}, 0);
            if (in_frame) check("tx_cont", 32'(mac_tx_valid), 1);
        end
    endtask

    task automatic step();
        logic [NPORT-1:0] acc;
        @(negedge clk);
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        cyc++;
        for (int p = 0; p < NPORT; p++) begin
            if (acc[p]) begin
                head[p]++;
                hold[p] = (head[p] != tail[p]) ? int'(src_mem[p][head[p]].gap) : 0;
            end else if (hold[p] > 0) begin
                hold[p]--;
            end
        end
        drive();
        monitor();
    endtask

    // stall_k > 0: source goes idle after stall_k bytes, so the MAC sees those bytes plus a 0x00 eof.
    task automatic add_frame(input int p, input int len, input int stall_k);
        item_t it;
        out_t  o;
        int    f;
        int    n;
        f = nfr[p];
        n = 0;
        for (int i = 0; i < len; i++) begin
            it.d   = 8'($urandom);
            it.sof = (i == 0);
            it.eof = (i == len - 1);
            it.gap = (stall_k > 0 && i == stall_k) ? 8'($urandom_range(1, 4)) : 8'd0;
            push_item(p, it);
            if ((stall_k > 0) ? (i < stall_k) : (i < MAX_LEN)) begin
                o.owner = 2'(p);
                o.data  = it.d;
                o.sof   = (i == 0);
                o.eof   = (stall_k == 0) && (i == len - 1 || i == MAX_LEN - 1);
                fbuf[p][f][n] = o;
                n++;
            end
        end
        if (stall_k > 0) begin
            o.owner = 2'(p);
            o.data  = 8'h00;
            o.sof   = 1'b0;
            o.eof   = 1'b1;
            fbuf[p][f][n] = o;
            n++;
            exp_under++;
        end else if (len > MAX_LEN) begin
            exp_over++;
        end
        flen[p][f] = n;
        nfr[p]++;
    endtask

    task automatic schedule();
        int rd [NPORT];
        int left;
        int p;
        left = 0;
        p = 0;
        for (int i = 0; i < NPORT; i++) begin
            rd[i] = 0;
            left += nfr[i];
        end
        while (left > 0) begin
`ifdef MAC_TX_ARB_STRICT_PRIO_EN
            for (int c = NPORT - 1; c >= 0; c--) if (rd[c] < nfr[c]) p = c;
`else
            for (int k = NPORT; k >= 1; k--) begin
                if (rd[(last_port + k) % NPORT] < nfr[(last_port + k) % NPORT])
                    p = (last_port + k) % NPORT;
            end
            last_port = p;
`endif
            for (int b = 0; b < flen[p][rd[p]]; b++) exp_q.push_back(fbuf[p][rd[p]][b]);
            rd[p]++;
            left--;
        end
        for (int i = 0; i < NPORT; i++) nfr[i] = 0;
    endtask

    function automatic bit sources_empty();
        for (int p = 0; p < NPORT; p++) if (head[p] != tail[p]) return 0;
        return 1;
    endfunction

    task automatic run_phase(input string name);
        bit done;
        done = 0;
        schedule();
        drive();
        for (int i = 0; i < 8000 && !done; i++) begin
            step();
            done = (exp_q.size() == 0) && sources_empty() && !busy;
        end
        check({name, "_done"}, 32'(done), 1);
        for (int i = 0; i < IFG + 4; i++) step();
        check({name, "_underrun_cnt"}, 32'(underrun_cnt), exp_under);
        check({name, "_oversize_cnt"}, 32'(oversize_cnt), exp_over);
        check({name, "_busy"}, 32'(busy), 0);
        $display("phase %s: checks=%0d errors=%0d", name, checks, errors);
    endtask

    task automatic reset_bench();
        for (int p = 0; p < NPORT; p++) begin
            head[p] = 0;
            tail[p] = 0;
            hold[p] = 0;
            nfr[p]  = 0;
        end
        exp_q.delete();
        last_port = NPORT - 1;
        exp_under = 0;
        exp_over  = 0;
        in_frame  = 0;
        have_eof  = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tx"}, {mac_tx_valid, mac_tx_sof, mac_tx_eof, mac_tx_data}, 0);
        check({tag, "_grant"}, 32'(grant), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_underrun"}, 32'(underrun_cnt), 0);
        check({tag, "_oversize"}, 32'(oversize_cnt), 0);
        check({tag, "_ready"}, 32'(req_ready), 0);
    endtask

    initial begin
        int p, len, stall;
        item_t g;
        rst = 1'b1;
        reset_bench();
        drive();
        for (int i = 0; i < 3; i++) step();
        rst = 1'b0;
        step();
        check_all_zero("reset");

        add_frame(0, 64, 0);
        run_phase("single64");

        for (int r = 0; r < 2; r++) for (int q = 0; q < NPORT; q++) add_frame(q, 10, 0);
        run_phase("rr_all");

        add_frame(1, 40, 20);
        run_phase("underrun");

        add_frame(0, 150, 0);
        add_frame(1, 10, 0);
        run_phase("oversize");

        for (int i = 0; i < 3; i++) begin
            g = '{gap: 8'd0, sof: 1'b0, eof: 1'b0, d: 8'($urandom)};
            push_item(2, g);
        end
        add_frame(2, 12, 0);
        run_phase("head_flush");

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) begin
                p = $urandom_range(0, NPORT - 1);
                len = $urandom_range(1, 130);
                stall = (len >= 2 && len <= MAX_LEN && $urandom_range(0, 3) == 0)
                        ? $urandom_range(1, len - 1) : 0;
                add_frame(p, len, stall);
            end
            run_phase("random");
        end

        add_frame(1, 50, 0);
        schedule();
        drive();
        begin
            int start_seen;
            bit reached;
            start_seen = out_seen;
            reached = 0;
            for (int i = 0; i < 200 && !reached; i++) begin
                step();
                reached = (out_seen >= start_seen + 10);
            end
            check("midreset_reached", 32'(reached), 1);
        end
        rst = 1'b1;
        exp_q.delete();
        in_frame = 0;
        have_eof = 0;
        step();
        check_all_zero("midreset");
        rst = 1'b0;
        reset_bench();
        drive();
        for (int q = NPORT - 1; q >= 0; q--) add_frame(q, 8, 0);
        begin
            out_t first;
            first = '0;
            schedule();
            if (exp_q.size() > 0) first = exp_q[0];
            check("after_reset_first_owner", 32'(first.owner), 0);
            nfr[0] = 0;
        end
        drive();
        begin
            bit done;
            done = 0;
            for (int i = 0; i < 2000 && !done; i++) begin
                step();
                done = (exp_q.size() == 0) && sources_empty() && !busy;
            end
            check("after_reset_done", 32'(done), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_tx_arb.md
Name: mac_tx_arb

Overview:
- Frame-level arbiter that shares one mac_rgmii TX logic port (mac_tx_data/valid/sof/eof, no backpressure) between NPORT frame sources, e.g. test_phy, a loopback path and an eth fifo TX side.
- Grants whole frames round-robin and forces a minimum idle gap between frames.
- Guards the MAC against source underrun and oversize frames by truncating with a forced eof, then draining the offending source.
- Sits between the sources and mac_tx_*, in the mac_gtx_clk domain.

Parameters:
- NPORT, 3, number of requesters (1..8).
- MAX_LEN, 1518, maximum bytes per frame passed to the MAC.
- IFG_CYCLES, 12, idle output cycles after every frame end (must be >= 1).
- CNT_W, 16, width of the error counters.

Ports:
- clk  in  1  single clock (mac_gtx_clk).
- rst  in  1  synchronous, active-high reset.
- req_data  in  NPORT*8  byte per port; port i uses bits [i*8 +: 8].
- req_valid  in  NPORT  byte valid.
- req_sof  in  NPORT  first byte of frame.
- req_eof  in  NPORT  last byte of frame.
- req_ready  out  NPORT  byte accepted when valid&ready.
- mac_tx_data  out  8  to mac_rgmii.
- mac_tx_valid  out  1
- mac_tx_sof  out  1
- mac_tx_eof  out  1
- grant  out  NPORT  one-hot owner of the current frame; 0 in IDLE/GAP.
- busy  out  1  state != IDLE.
- underrun_cnt  out  CNT_W  saturating count of underruns.
- oversize_cnt  out  CNT_W  saturating count of oversize frames.

Behaviour:
- Reset: all outputs 0; state IDLE; round-robin pointer set so port 0 has highest priority; counters cleared. Reset in any state aborts immediately, with no eof emitted.
- Request: port i requests when req_valid[i] & req_sof[i].
- Head flush: in IDLE, a port with valid & !sof at its head gets req_ready=1 and that byte is discarded silently.
- States: IDLE, STREAM, TRUNC, DRAIN, GAP.
- IDLE:
  - If any request is present, pick the first requesting port after the last granted one (round-robin).
  - Register grant and go to STREAM. No byte is accepted in this cycle.
- STREAM:
  - req_ready = grant.
  - Each accepted byte appears on mac_tx_* exactly 1 cycle later (registered). sof passes on the first byte only. len counts from 1.
  - Accepted byte with eof: output with eof=1, go to GAP.
  - Accepted byte with len == MAX_LEN and no eof: output with eof forced to 1, oversize_cnt++, go to DRAIN.
  - Granted req_valid low in any STREAM cycle (underrun): next state TRUNC.
  - A 1-byte frame (sof&eof on the same byte) is legal.
- TRUNC:
  - Output one byte 0x00 with valid=1, eof=1; underrun_cnt++.
  - If the source has not yet delivered eof, go to DRAIN; otherwise go to GAP.
- DRAIN:
  - req_ready = grant; bytes are discarded and nothing is output.
  - On an accepted eof byte, go to GAP.
- GAP:
  - Grant cleared; mac_tx_valid=0 for IFG_CYCLES cycles, then IDLE.
  - Minimum spacing from one output eof to the next output sof is IFG_CYCLES+2 cycles.
- Output qualifiers: mac_tx_sof/eof are 0 whenever mac_tx_valid=0. mac_tx_valid is never low between sof and eof of an emitted frame.
- Counters saturate at all-ones.

Optional Feature:
- Macro: MAC_TX_ARB_STRICT_PRIO_EN.
- Defined: fixed priority, lowest index wins. The round-robin pointer is not implemented.
- Undefined: round-robin as above.
- All other behaviour is identical.

Decomposition:
- Package mac_tx_arb_pkg:
  - state enum (IDLE, STREAM, TRUNC, DRAIN, GAP);
  - LEN_W = $clog2(MAX_LEN+1);
  - TRUNC_FILL byte constant 8'h00.
- Sub-module rr_arbiter:
  - request vector in, one-hot grant out;
  - pointer update on an accept strobe;
  - holds the strict-priority macro switch.

Test Plan:
- Port0 sends a 64-byte frame, others idle -> identical 64 bytes on mac_tx_* 1 cycle delayed, sof on byte 0, eof on byte 63; grant=001 during the frame; 12 idle cycles follow.
- All 3 ports request back-to-back 10-byte frames -> output order 0,1,2,0,1,2; each gap >= 14 cycles from eof to sof. With MAC_TX_ARB_STRICT_PRIO_EN defined -> port0 only while it keeps requesting.
- Port1 drops valid after byte 20 of 40 -> 20 bytes out, then 0x00 with eof; underrun_cnt=1; the remaining bytes are drained; no output until GAP ends.
- MAX_LEN=100, 150-byte frame -> 100 bytes out with eof on byte 100; oversize_cnt=1; 50 bytes drained; next frame unaffected.
- Port2 head holds 3 non-sof bytes in IDLE -> all flushed with no output; the following sof frame passes normally.
- rst asserted mid-STREAM -> next cycle all outputs 0 and counters 0; a new frame after reset is granted to port 0 first.
